// File: rtl/mem_bus_arbiter2_if.sv
// Bus bundle for the two-master round-robin memory arbiter.
// slave: the arbiter's view; master: requesters, memory and irq controller.
interface mem_bus_arbiter2_if;
    logic        m0_valid;
    logic        m0_instr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_instr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_instr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic [1:0]  grant;
    logic        timeout_irq;
    logic        eoi;

    modport slave (
        input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        output grant, timeout_irq,
        input  eoi
    );

    modport master (
        output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata,
        input  grant, timeout_irq,
        output eoi
    );
endinterface

// File: rtl/mem_bus_arbiter2.sv
// Two-master round-robin arbiter/sequencer for the native mem bus,
// with a BUSY-phase watchdog that aborts hung transfers and raises an irq.
module mem_bus_arbiter2 #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               resetn,
    mem_bus_arbiter2_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // The abort fires on the BUSY cycle that would make the count reach
    // TIMEOUT_CYCLES, so compare against one less than the limit.
    localparam logic [CW-1:0] LIMIT =
        CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic          last_grant;
    logic          owner;
    logic [1:0]    grant;
    logic          s_valid;
    logic          s_instr;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          m0_ready;
    logic          m1_ready;
    logic [31:0]   m0_rdata;
    logic [31:0]   m1_rdata;
    logic          irq;
    logic [CW-1:0] wd_cnt;

    logic [1:0]    req;
    logic          win;
    logic          sel_instr;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_wstrb;
    logic          slv_done;
    logic          wd_abort;
    logic          finish;
    logic [31:0]   resp_rdata;

    // Pick the winner: a sole requester, or on a tie the one not served last.
    always_comb begin
        req = {bus.m1_valid, bus.m0_valid};
        win = 1'b0;
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant;
            default: win = 1'b0;
        endcase
        sel_instr = win ? bus.m1_instr : bus.m0_instr;
        sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        sel_wstrb = win ? bus.m1_wstrb : bus.m0_wstrb;
    end

    // Completion sources: slave ready wins over a same-cycle watchdog hit.
    always_comb begin
        slv_done   = (state == BUSY) && bus.s_ready;
        wd_abort   = WD_EN && (state == BUSY) && !bus.s_ready
                     && (wd_cnt == LIMIT);
        finish     = slv_done || wd_abort;
        resp_rdata = slv_done ? bus.s_rdata : ERR_RDATA;
    end

    // Sequencer: latch the granted request, hold it on the slave port.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            grant      <= 2'b00;
            s_valid    <= 1'b0;
            s_instr    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        s_valid    <= 1'b1;
                        s_instr    <= sel_instr;
                        s_addr     <= sel_addr;
                        s_wdata    <= sel_wdata;
                        s_wstrb    <= sel_wstrb;
                        grant      <= win ? 2'b10 : 2'b01;
                        last_grant <= win;
                        owner      <= win;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        s_valid <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    grant   <= 2'b00;
                    s_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Response path: one-cycle ready pulse to the owner only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (finish) begin
            if (owner) begin
                m1_ready <= 1'b1;
                m1_rdata <= resp_rdata;
            end else begin
                m0_ready <= 1'b1;
                m0_rdata <= resp_rdata;
            end
        end else if (state == RESP) begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end
    end

    // Watchdog: count stalled BUSY cycles, saturating, cleared otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (WD_EN && (state == BUSY) && !finish) begin
            if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    // Sticky abort irq; a new abort beats a same-cycle eoi.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else if (wd_abort) begin
            irq <= 1'b1;
        end else if (bus.eoi) begin
            irq <= 1'b0;
        end
    end

    assign bus.s_valid     = s_valid;
    assign bus.s_instr     = s_instr;
    assign bus.s_addr      = s_addr;
    assign bus.s_wdata     = s_wdata;
    assign bus.s_wstrb     = s_wstrb;
    assign bus.m0_ready    = m0_ready;
    assign bus.m0_rdata    = m0_rdata;
    assign bus.m1_ready    = m1_ready;
    assign bus.m1_rdata    = m1_rdata;
    assign bus.grant       = grant;
    assign bus.timeout_irq = irq;

endmodule

// File: tb/tb_mem_bus_arbiter2.sv
// Bench for mem_bus_arbiter2: transaction-level model plus directed tests
// (single read, fairness, write, watchdog abort, limit race, reset).
module tb_mem_bus_arbiter2;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk;
    logic resetn;
    int   cyc;

    mem_bus_arbiter2_if bus ();

    mem_bus_arbiter2 #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // bench-driven stimulus
    logic        mv [2];
    logic        mi [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        sr;
    logic [31:0] srd;
    logic        eoi_r;

    assign bus.m0_valid = mv[0];
    assign bus.m0_instr = mi[0];
    assign bus.m0_addr  = ma[0];
    assign bus.m0_wdata = mw[0];
    assign bus.m0_wstrb = ms[0];
    assign bus.m1_valid = mv[1];
    assign bus.m1_instr = mi[1];
    assign bus.m1_addr  = ma[1];
    assign bus.m1_wdata = mw[1];
    assign bus.m1_wstrb = ms[1];
    assign bus.s_ready  = sr;
    assign bus.s_rdata  = srd;
    assign bus.eoi      = eoi_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // transaction model: a transfer granted at edge m_start ends at the
    // first later edge with s_ready, or TO edges after the grant
    int          mn;
    int          m_start;
    int          m_owner;
    int          m_last;
    bit          m_busy;
    bit          m_resp;
    logic [1:0]  exp_grant;
    logic        exp_sv;
    logic        exp_si;
    logic [31:0] exp_sa;
    logic [31:0] exp_sw;
    logic [3:0]  exp_ss;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_rd [2];
    logic        exp_irq;

    wire mdl_end   = resetn && m_busy && !m_resp
                     && (sr || (mn - m_start >= TO));
    wire mdl_abort = mdl_end && !sr;

    function automatic int pick(input logic a, input logic b, input int last);
        if (a && b) return 1 - last;
        return b ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        mn <= mn + 1;
        if (!resetn) begin
            m_busy    <= 1'b0;
            m_resp    <= 1'b0;
            m_last    <= 1;
            m_owner   <= 0;
            exp_grant <= 2'b00;
            exp_sv    <= 1'b0;
            exp_si    <= 1'b0;
            exp_sa    <= '0;
            exp_sw    <= '0;
            exp_ss    <= '0;
            exp_rdy   <= 2'b00;
            exp_rd[0] <= '0;
            exp_rd[1] <= '0;
        end else if (m_resp) begin
            m_resp    <= 1'b0;
            exp_rdy   <= 2'b00;
            exp_rd[0] <= '0;
            exp_rd[1] <= '0;
            exp_grant <= 2'b00;
        end else if (m_busy) begin
            if (mdl_end) begin
                m_busy           <= 1'b0;
                m_resp           <= 1'b1;
                exp_sv           <= 1'b0;
                exp_rdy[m_owner] <= 1'b1;
                exp_rd[m_owner]  <= sr ? srd : ERR;
            end
        end else if (mv[0] || mv[1]) begin
            m_owner   <= pick(mv[0], mv[1], m_last);
            m_last    <= pick(mv[0], mv[1], m_last);
            m_busy    <= 1'b1;
            m_start   <= mn;
            exp_sv    <= 1'b1;
            exp_grant <= (pick(mv[0], mv[1], m_last) == 1) ? 2'b10 : 2'b01;
            exp_si    <= mi[pick(mv[0], mv[1], m_last)];
            exp_sa    <= ma[pick(mv[0], mv[1], m_last)];
            exp_sw    <= mw[pick(mv[0], mv[1], m_last)];
            exp_ss    <= ms[pick(mv[0], mv[1], m_last)];
        end
        if (!resetn)        exp_irq <= 1'b0;
        else if (mdl_abort) exp_irq <= 1'b1;
        else if (eoi_r)     exp_irq <= 1'b0;
    end

    // bench bookkeeping
    int          passed;
    int          total;
    int          slv_k;
    int          scnt;
    logic        late_rdy;
    logic [31:0] slv_rdata;
    int          left [2];
    int          n_rdy [2];
    int          rdy_cyc [2];
    int          req_cyc [2];
    logic [31:0] rd_val [2];
    logic        irq_at [2];
    bit          got [2];
    int          sv_cnt;
    logic [1:0]  prev_g;
    logic [1:0]  glog [$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, want);
    endtask

    task automatic got_ready(input int m, input logic [31:0] rd);
        n_rdy[m]++;
        rd_val[m]  = rd;
        rdy_cyc[m] = cyc;
        irq_at[m]  = bus.timeout_irq;
        got[m]     = 1'b1;
        if (left[m] > 0) left[m]--;
        if (left[m] > 0) begin
            ma[m] = ma[m] + 32'd4;
            mw[m] = mw[m] + 32'd1;
        end else begin
            mv[m] = 1'b0;
        end
    endtask

    // one cycle: compare against the model, then drive slave and masters
    task automatic tick();
        @(negedge clk);
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("s_valid", 32'(bus.s_valid), 32'(exp_sv));
        check("m0_ready", 32'(bus.m0_ready), 32'(exp_rdy[0]));
        check("m1_ready", 32'(bus.m1_ready), 32'(exp_rdy[1]));
        check("m0_rdata", bus.m0_rdata, exp_rd[0]);
        check("m1_rdata", bus.m1_rdata, exp_rd[1]);
        check("timeout_irq", 32'(bus.timeout_irq), 32'(exp_irq));
        if (exp_sv) begin
            check("s_addr", bus.s_addr, exp_sa);
            check("s_wdata", bus.s_wdata, exp_sw);
            check("s_wstrb", 32'(bus.s_wstrb), 32'(exp_ss));
            check("s_instr", 32'(bus.s_instr), 32'(exp_si));
        end
        if (bus.s_valid) sv_cnt++;
        if (bus.grant != 2'b00 && prev_g == 2'b00) glog.push_back(bus.grant);
        prev_g = bus.grant;
        if (bus.s_valid) begin
            scnt++;
            sr = (slv_k >= 0) && (scnt == slv_k + 1);
        end else begin
            scnt = 0;
            sr   = late_rdy;
        end
        srd = slv_rdata;
        if (bus.m0_ready) got_ready(0, bus.m0_rdata);
        if (bus.m1_ready) got_ready(1, bus.m1_rdata);
    endtask

    task automatic req(input int m, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s,
                       input logic ins, input int n);
        mv[m]      = 1'b1;
        ma[m]      = a;
        mw[m]      = w;
        ms[m]      = s;
        mi[m]      = ins;
        left[m]    = n;
        req_cyc[m] = cyc;
    endtask

    task automatic wait_ready(input int m, input int lim);
        got[m] = 1'b0;
        for (int i = 0; i < lim && !got[m]; i++) tick();
        check("wait_ready", 32'(got[m]), 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        mv[0]  = 1'b0;
        mv[1]  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        cyc = 0; mn = 0; m_start = 0; passed = 0; total = 0;
        resetn = 1'b0; sr = 1'b0; srd = '0; eoi_r = 1'b0;
        slv_k = 0; scnt = 0; late_rdy = 1'b0; slv_rdata = '0;
        sv_cnt = 0; prev_g = 2'b00;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mi[m] = 1'b0; ma[m] = '0; mw[m] = '0;
            ms[m] = '0; left[m] = 0; n_rdy[m] = 0; rdy_cyc[m] = 0;
            req_cyc[m] = 0; rd_val[m] = '0; irq_at[m] = 1'b0;
            got[m] = 1'b0;
        end
        do_reset();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_s_valid", 32'(bus.s_valid), 32'd0);
        check("rst_irq", 32'(bus.timeout_irq), 32'd0);

        // single m0 read, slave ready one cycle after s_valid
        slv_k = 1;
        slv_rdata = 32'h1234_5678;
        req(0, 32'h2000_0000, 32'h0, 4'h0, 1'b1, 1);
        tick();
        check("t1_grant", 32'(bus.grant), 32'd1);
        wait_ready(0, 20);
        check("t1_latency", 32'(rdy_cyc[0] - req_cyc[0]), 32'd3);
        check("t1_rdata", rd_val[0], 32'h1234_5678);
        check("t1_m1_quiet", 32'(n_rdy[1]), 32'd0);
        tick();

        // both masters streaming four transfers each
        do_reset();
        glog.delete();
        n_rdy[0] = 0;
        n_rdy[1] = 0;
        slv_k = 0;
        slv_rdata = 32'h0BAD_F00D;
        req(0, 32'h0000_1000, 32'h10, 4'h0, 1'b0, 4);
        req(1, 32'h4000_0000, 32'h20, 4'h3, 1'b0, 4);
        for (int i = 0; i < 200 && (n_rdy[0] < 4 || n_rdy[1] < 4); i++)
            tick();
        check("t2_m0_count", 32'(n_rdy[0]), 32'd4);
        check("t2_m1_count", 32'(n_rdy[1]), 32'd4);
        check("t2_grants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check("t2_grant_seq", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        tick();

        // m1 write with a slow slave
        slv_k = 3;
        slv_rdata = 32'h0000_00A1;
        n_rdy[1] = 0;
        req(1, 32'h8100_5004, 32'h6, 4'hF, 1'b0, 1);
        tick();
        check("t3_s_addr", bus.s_addr, 32'h8100_5004);
        check("t3_s_wdata", bus.s_wdata, 32'h0000_0006);
        check("t3_s_wstrb", 32'(bus.s_wstrb), 32'hF);
        wait_ready(1, 20);
        check("t3_pulses", 32'(n_rdy[1]), 32'd1);
        check("t3_rdata", rd_val[1], 32'h0000_00A1);
        tick();

        // watchdog abort, late ready ignored, eoi clears
        slv_k = -1;
        late_rdy = 1'b1;
        sv_cnt = 0;
        req(0, 32'h2000_0040, 32'h0, 4'h0, 1'b0, 1);
        wait_ready(0, 30);
        check("t4_busy_cycles", 32'(sv_cnt), 32'd8);
        check("t4_err_rdata", rd_val[0], 32'hDEAD_BEEF);
        check("t4_irq_at_ready", 32'(irq_at[0]), 32'd1);
        tick();
        tick();
        tick();
        late_rdy = 1'b0;
        check("t4_idle_grant", 32'(bus.grant), 32'd0);
        check("t4_irq_sticky", 32'(bus.timeout_irq), 32'd1);
        eoi_r = 1'b1;
        tick();
        eoi_r = 1'b0;
        check("t4_eoi_clear", 32'(bus.timeout_irq), 32'd0);

        // abort with eoi held high: abort wins, then eoi clears
        eoi_r = 1'b1;
        req(0, 32'h2000_0080, 32'h0, 4'h0, 1'b0, 1);
        wait_ready(0, 30);
        check("t4b_irq_wins", 32'(irq_at[0]), 32'd1);
        tick();
        check("t4b_irq_cleared", 32'(bus.timeout_irq), 32'd0);
        eoi_r = 1'b0;
        tick();

        // s_ready on the exact limit cycle
        slv_k = TO - 1;
        slv_rdata = 32'hCAFE_0005;
        sv_cnt = 0;
        req(0, 32'h2000_00C0, 32'h0, 4'h0, 1'b0, 1);
        wait_ready(0, 30);
        check("t5_busy_cycles", 32'(sv_cnt), 32'd8);
        check("t5_rdata", rd_val[0], 32'hCAFE_0005);
        check("t5_no_irq", 32'(irq_at[0]), 32'd0);
        tick();

        // reset while BUSY, then a tie goes to m0
        slv_k = -1;
        n_rdy[0] = 0;
        req(0, 32'h3000_0000, 32'h0, 4'h0, 1'b1, 1);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        mv[0] = 1'b0;
        tick();
        check("t6_s_valid", 32'(bus.s_valid), 32'd0);
        check("t6_grant", 32'(bus.grant), 32'd0);
        check("t6_m0_ready", 32'(bus.m0_ready), 32'd0);
        resetn = 1'b1;
        tick();
        check("t6_no_resp", 32'(n_rdy[0]), 32'd0);
        slv_k = 0;
        req(0, 32'h3000_0100, 32'h0, 4'h0, 1'b0, 1);
        req(1, 32'h3000_0200, 32'h0, 4'h0, 1'b0, 1);
        tick();
        check("t6_tie_m0", 32'(bus.grant), 32'd1);
        wait_ready(1, 30);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
